// File: rtl/uart_rx_parity_check.sv
// 8O1 UART receiver: 2-flop synchroniser, mid-bit sampling, odd-parity
// and stop-bit checking. One rx_valid pulse per frame. Data and flags are
// held until the next frame completes.
module uart_rx_parity_check #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t          state, state_nx;
  logic            rx_meta, rxs;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            acc, par_bit;
  logic            mid_bit, half_bit;
  logic            sample_data, sample_par, sample_stop, start_ok;

  assign mid_bit  = (cnt == CNT_LAST);
  assign half_bit = (cnt == CNT_HALF);
  assign busy     = (state != IDLE);

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic and sampling strobes.
  always_comb begin
    state_nx    = state;
    sample_data = 1'b0;
    sample_par  = 1'b0;
    sample_stop = 1'b0;
    start_ok    = 1'b0;
    case (state)
      IDLE:      if (!rxs) state_nx = START;
      START:     if (half_bit) begin
                   if (rxs) state_nx = IDLE;   // glitch, not a start bit
                   else begin
                     state_nx = DATA;
                     start_ok = 1'b1;
                   end
                 end
      DATA:      if (mid_bit) begin
                   sample_data = 1'b1;
                   if (bit_idx == 3'd7) state_nx = PARITY;
                 end
      PARITY:    if (mid_bit) begin
                   sample_par = 1'b1;
                   state_nx   = STOP;
                 end
      STOP:      if (mid_bit) begin
                   sample_stop = 1'b1;
                   // a low stop bit may be a break; wait for the line to recover
                   state_nx    = rxs ? IDLE : WAIT_HIGH;
                 end
      WAIT_HIGH: if (rxs) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Baud counter: free-runs within a state, cleared on every transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   cnt <= '0;
    else if (state_nx != state || state == IDLE) cnt <= '0;
    else if (mid_bit)                           cnt <= '0;
    else                                        cnt <= cnt + CW'(1);
  end

  // Shift register, bit index and running parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx <= '0;
      shreg   <= '0;
      acc     <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      if (start_ok) begin
        bit_idx <= '0;
        acc     <= 1'b0;
      end
      if (sample_data) begin
        shreg[bit_idx] <= rxs;
        acc            <= acc ^ rxs;
        bit_idx        <= bit_idx + 3'd1;
      end
      if (sample_par) par_bit <= rxs;
    end
  end

  // Output register: byte and flags update together with the rx_valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= sample_stop;
      if (sample_stop) begin
        rx_data    <= shreg;
        parity_err <= ~(acc ^ par_bit);  // odd parity: data + p must hold odd ones
        frame_err  <= ~rxs;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_parity_check.sv
// Directed bench for uart_rx_parity_check (8O1, CLKS_PER_BIT = 16).
module tb_uart_rx_parity_check;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, busy;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // rx_valid monitor: counts pulses and records the last two deliveries.
  int         vcount = 0;
  int         last_cyc = 0, prev_cyc = 0;
  logic [7:0] last_data = 8'h00, prev_data = 8'h00;
  logic       last_pe = 1'b0, last_fe = 1'b0, prev_pe = 1'b0, prev_fe = 1'b0;

  uart_rx_parity_check #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      vcount    <= vcount + 1;
      prev_cyc  <= last_cyc;
      prev_data <= last_data;
      prev_pe   <= last_pe;
      prev_fe   <= last_fe;
      last_cyc  <= cyc;
      last_data <= rx_data;
      last_pe   <= parity_err;
      last_fe   <= frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_period(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic s);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
    bit_period(p);
    bit_period(s);
  endtask

  task automatic idle(input int nbits);
    rxd = 1'b1;
    repeat (nbits * CPB) @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  {24'h0, rx_data}, 32'h00);
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_perr",  {31'h0, parity_err}, 32'h0);
    check("rst_ferr",  {31'h0, frame_err}, 32'h0);
    check("rst_busy",  {31'h0, busy}, 32'h0);
    rst = 1'b1;
    idle(2);

    // 0x55 with correct parity (four ones -> p=1)
    base = vcount;
    send(8'h55, 1'b1, 1'b1);
    idle(2);
    check("t1_count", vcount - base, 32'd1);
    check("t1_data",  {24'h0, last_data}, 32'h55);
    check("t1_perr",  {31'h0, last_pe}, 32'h0);
    check("t1_ferr",  {31'h0, last_fe}, 32'h0);
    check("t1_busy",  {31'h0, busy}, 32'h0);

    // 0x55 with wrong parity, then 0x80 with correct parity (one 1 -> p=0)
    send(8'h55, 1'b0, 1'b1);
    idle(2);
    check("t2a_data", {24'h0, rx_data}, 32'h55);
    check("t2a_perr", {31'h0, parity_err}, 32'h1);
    check("t2a_ferr", {31'h0, frame_err}, 32'h0);
    send(8'h80, 1'b0, 1'b1);
    idle(2);
    check("t2b_data", {24'h0, rx_data}, 32'h80);
    check("t2b_perr", {31'h0, parity_err}, 32'h0);

    // back-to-back 0xFF / 0x00, no idle gap
    base = vcount;
    send(8'hFF, 1'b1, 1'b1);
    send(8'h00, 1'b1, 1'b1);
    idle(2);
    check("t3_count", vcount - base, 32'd2);
    check("t3_gap",   last_cyc - prev_cyc, 11 * CPB);
    check("t3_data0", {24'h0, prev_data}, 32'hFF);
    check("t3_data1", {24'h0, last_data}, 32'h00);
    check("t3_err0",  {30'h0, prev_pe, prev_fe}, 32'h0);
    check("t3_err1",  {30'h0, last_pe, last_fe}, 32'h0);

    // short glitch: low for CPB/4 cycles
    base = vcount;
    rxd = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (CPB / 2 + 3 - CPB / 4) @(posedge clk);
    #1;
    check("t4_busy",  {31'h0, busy}, 32'h0);
    idle(2);
    check("t4_count", vcount - base, 32'd0);

    // 0xA5 (four ones, p=1) with low stop, then a break for 3 bit periods
    base = vcount;
    send(8'hA5, 1'b1, 1'b0);
    rxd = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("t5_count", vcount - base, 32'd1);
    check("t5_data",  {24'h0, rx_data}, 32'hA5);
    check("t5_ferr",  {31'h0, frame_err}, 32'h1);
    check("t5_perr",  {31'h0, parity_err}, 32'h0);
    check("t5_busy",  {31'h0, busy}, 32'h1);
    idle(2);
    check("t5_busy_rel", {31'h0, busy}, 32'h0);
    check("t5_count2",   vcount - base, 32'd1);
    send(8'h3C, 1'b1, 1'b1);
    idle(2);
    check("t5_data2", {24'h0, rx_data}, 32'h3C);
    check("t5_ferr2", {31'h0, frame_err}, 32'h0);

    // reset mid-DATA of 0x12, then 0x34 (three ones, p=0)
    base = vcount;
    bit_period(1'b0);
    bit_period(1'b0);
    bit_period(1'b1);
    bit_period(1'b0);
    rst = 1'b0;
    #1;
    check("t6_rst_data",  {24'h0, rx_data}, 32'h00);
    check("t6_rst_flags", {29'h0, rx_valid, parity_err, frame_err}, 32'h0);
    check("t6_rst_busy",  {31'h0, busy}, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(12);
    check("t6_noframe", vcount - base, 32'd0);
    send(8'h34, 1'b0, 1'b1);
    idle(2);
    check("t6_count", vcount - base, 32'd1);
    check("t6_data",  {24'h0, rx_data}, 32'h34);
    check("t6_errs",  {30'h0, parity_err, frame_err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity_check.md
Name: uart_rx_parity_check

Overview:
- RS232 receive path for 8-bit, odd-parity frames (8O1).
- Deserialises the asynchronous rxd line, LSB first, and recomputes odd parity over the 8 data bits.
- Compares the recomputed bit with the received parity bit; odd parity means data plus parity bit contain an odd number of 1s.
- Checks the stop bit and presents each byte with error flags. Sits between the line interface and the byte consumer, opposite the transmit-side parity generator.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per bit period; integer >= 4, even.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  8  last received byte; held until the next frame completes.
- rx_valid  output  1  one-cycle pulse when rx_data and the error flags update.
- parity_err  output  1  1 = received parity bit does not give odd total ones; held until the next rx_valid.
- frame_err  output  1  1 = stop bit sampled low; held until the next rx_valid.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous while rst=0:
  - rx_data=0x00, rx_valid=0, parity_err=0, frame_err=0, busy=0.
  - State=IDLE; synchroniser flops=1; bit counter=0; baud counter=0.
- Reset asserted mid-frame aborts the frame; no rx_valid is produced for it.
- Input path:
  - rxd passes through a 2-flop synchroniser; rxs denotes its output.
  - All sampling below uses rxs only.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - Cleared on every state transition.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - rxs=0 -> START, counter cleared.
- START:
  - When counter = CLKS_PER_BIT/2-1 (mid start bit), sample rxs.
  - rxs=0 -> DATA, bit index=0.
  - rxs=1 -> IDLE (glitch rejected, no outputs change).
- DATA:
  - When counter = CLKS_PER_BIT-1 (mid-bit), sample rxs into shift register position bit index (LSB first).
  - Running parity accumulator ^= sample.
  - After bit index 7 -> PARITY.
- PARITY:
  - At mid-bit, capture p = rxs -> STOP.
- STOP:
  - At mid-bit, sample s = rxs.
  - Next cycle: rx_valid=1 for exactly one cycle.
  - Same cycle: rx_data = shift register, parity_err = ~(acc ^ p), frame_err = ~s.
  - s=1 -> IDLE.
  - s=0 -> WAIT_HIGH.
  - Byte is delivered even when either error flag is set.
- WAIT_HIGH:
  - Stays until rxs=1, then -> IDLE.
  - A break condition (held low) produces exactly one frame_err report and no repeated frames.
- Flag rules:
  - parity_err and frame_err change only in the rx_valid cycle.
  - Both flags may be 1 in the same rx_valid cycle.
- Timing:
  - Frame length = 11 bit periods.
  - rx_valid asserts within the stop bit, after its mid-point; a new start edge is accepted from the cycle after rx_valid.
  - Back-to-back frames with a 1-bit stop and no idle gap must be received without loss.
- rxd activity during busy does not restart a frame; only the state machine sequence above applies.

Test Plan:
- Send 0x55 (four 1s), parity bit 1, stop 1 -> rx_valid pulse exactly once, rx_data=0x55, parity_err=0, frame_err=0, busy low after stop.
- Send 0x55, parity bit 0, stop 1 -> rx_data=0x55, parity_err=1, frame_err=0. Then send 0x80 with parity 0 -> parity_err=0, rx_data=0x80.
- Send 0xFF with parity 1, then 0x00 with parity 1, back-to-back with no idle gap -> two rx_valid pulses, 11*CLKS_PER_BIT cycles apart; rx_data 0xFF then 0x00; no errors.
- Drive rxd low for CLKS_PER_BIT/4 cycles only, then high -> no rx_valid; busy returns to 0 by CLKS_PER_BIT/2+3 cycles after the edge.
- Send 0xA5 with parity 1 and stop bit 0, then hold rxd low for 3 bit periods -> one rx_valid with rx_data=0xA5, frame_err=1, parity_err=0. busy stays 1 until rxd returns high. Next valid frame 0x3C (parity 1) -> frame_err=0.
- Assert rst low mid-DATA of frame 0x12, release, then send 0x34 with parity 0 -> no rx_valid for 0x12; outputs at reset values during rst; 0x34 received with no errors.
